// File: rtl/pulse_width_meter_if.sv
// rtl/pulse_width_meter_if.sv - result handshake bundle for pulse_width_meter
interface pulse_width_meter_if #(
    parameter int CNT_W = 16
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] meas_width;
    logic             meas_ovf;
    logic             meas_lost;

    modport master (output meas_valid, meas_width, meas_ovf, meas_lost, input meas_ready);
    modport slave  (input meas_valid, meas_width, meas_ovf, meas_lost, output meas_ready);
endinterface

// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - microsecond pulse high-time meter with valid/ready result
// Build option: PULSE_PERIOD_EN measures rise-to-rise period instead of high time.
module pulse_width_meter #(
    parameter int CLK_PER_US = 50,
    parameter int CNT_W      = 16
) (
    input  logic                CLK_50M,
    input  logic                RST,
    input  logic                sig_in,
    output logic                busy,
    pulse_width_meter_if.master meas
);
    localparam int               PW       = $clog2(CLK_PER_US);
    localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_PER_US - 1);
    localparam logic [PW-1:0]    PRE_TICK = PW'(CLK_PER_US - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(CNT_MAX - 1'b1);

    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [2:0]       primed;
    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] cnt;
    logic             ovf_int;
    logic             rise, fall, end_evt, tick;

    // Edges only count once s3 holds a real sample, so a level already high
    // at reset release never looks like a rising edge.
    assign rise = s2 & ~s3 & primed[2];
    assign fall = ~s2 & s3 & primed[2];
`ifdef PULSE_PERIOD_EN
    assign end_evt = rise;
`else
    assign end_evt = fall;
`endif
    // The rise cycle is the first clock of the first microsecond, so the
    // count increments as the prescaler reaches its terminal value.
    assign tick = (pre == PRE_TICK);

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state           <= IDLE;
            s1              <= 1'b0;
            s2              <= 1'b0;
            s3              <= 1'b0;
            primed          <= '0;
            pre             <= '0;
            cnt             <= '0;
            ovf_int         <= 1'b0;
            busy            <= 1'b0;
            meas.meas_valid <= 1'b0;
            meas.meas_width <= '0;
            meas.meas_ovf   <= 1'b0;
            meas.meas_lost  <= 1'b0;
        end else begin
            s1     <= sig_in;
            s2     <= s1;
            s3     <= s2;
            primed <= {primed[1:0], 1'b1};
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEASURE;
                        busy    <= 1'b1;
                        pre     <= '0;
                        cnt     <= '0;
                        ovf_int <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (end_evt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
                        if (tick) begin
                            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                            if (cnt >= CNT_NEAR) ovf_int <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!meas.meas_valid) begin
                        meas.meas_width <= cnt;
                        meas.meas_ovf   <= ovf_int;
                        meas.meas_valid <= 1'b1;
                    end else if (meas.meas_ready) begin
                        meas.meas_valid <= 1'b0;
                        meas.meas_lost  <= rise;
                        state           <= IDLE;
                    end else if (rise) begin
                        meas.meas_lost <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed self-checking bench for pulse_width_meter
module tb_pulse_width_meter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;
    logic sig4 = 1'b0;
    logic busy, busy4;
    int   n_pass = 0;
    int   n_total = 0;

    pulse_width_meter_if #(.CNT_W(16)) mi ();
    pulse_width_meter_if #(.CNT_W(4))  mi4 ();

    pulse_width_meter #(.CLK_PER_US(50), .CNT_W(16)) u_dut (
        .CLK_50M(clk), .RST(rst), .sig_in(sig), .busy(busy), .meas(mi)
    );
    pulse_width_meter #(.CLK_PER_US(50), .CNT_W(4)) u_dut4 (
        .CLK_50M(clk), .RST(rst), .sig_in(sig4), .busy(busy4), .meas(mi4)
    );

    always #10 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        sig = 1'b1;
        cyc(n);
        sig = 1'b0;
    endtask

    task automatic accept();
        mi.meas_ready = 1'b1;
        cyc(1);
        mi.meas_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b1;
        while (mi.meas_valid !== 1'b1) begin
            if (lat >= budget) begin
                ok = 1'b0;
                return;
            end
            cyc(1);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        n_total++; if (mi.meas_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", mi.meas_valid); else n_pass++;
        n_total++; if (mi.meas_width !== 16'd0) $display("FAIL rst_width: got %0d expected 0", mi.meas_width); else n_pass++;
        n_total++; if (mi.meas_ovf !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", mi.meas_ovf); else n_pass++;
        n_total++; if (mi.meas_lost !== 1'b0) $display("FAIL rst_lost: got %b expected 0", mi.meas_lost); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (mi4.meas_valid !== 1'b0) $display("FAIL rst_valid4: got %b expected 0", mi4.meas_valid); else n_pass++;
        rst = 1'b0;
        cyc(3);
    endtask

    task automatic test_basic();
        int lat;
        bit ok;
        sig = 1'b1;
        cyc(250);
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_mid: got %b expected 1", busy); else n_pass++;
        cyc(250);
        sig = 1'b0;
        cyc(1);
        wait_valid(10, lat, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL basic_timeout: got %b expected 1", ok); else n_pass++;
        n_total++; if (lat != 3) $display("FAIL basic_latency: got %0d expected 3", lat); else n_pass++;
        n_total++; if (mi.meas_width !== 16'd10) $display("FAIL basic_width: got %0d expected 10", mi.meas_width); else n_pass++;
        n_total++; if (mi.meas_ovf !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", mi.meas_ovf); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_done: got %b expected 0", busy); else n_pass++;
        cyc(5);
        n_total++; if (mi.meas_valid !== 1'b1 || mi.meas_width !== 16'd10) $display("FAIL basic_hold: got valid=%b width=%0d expected valid=1 width=10", mi.meas_valid, mi.meas_width); else n_pass++;
        accept();
        n_total++; if (mi.meas_valid !== 1'b0) $display("FAIL basic_accept: got %b expected 0", mi.meas_valid); else n_pass++;
        cyc(3);
    endtask

    task automatic test_boundary();
        int lens [6] = '{49, 50, 1, 100, 149, 150};
        int exps [6] = '{0, 1, 0, 2, 2, 3};
        int lat;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            pulse(lens[i]);
            wait_valid(20, lat, ok);
            n_total++; if (ok !== 1'b1) $display("FAIL bound_timeout_%0d: got %b expected 1", lens[i], ok); else n_pass++;
            n_total++;
            if (lens[i] == 50 ? (mi.meas_width > 16'd1) : (mi.meas_width !== 16'(exps[i])))
                $display("FAIL bound_width_%0d: got %0d expected %0d", lens[i], mi.meas_width, exps[i]);
            else
                n_pass++;
            accept();
            cyc(3);
        end
    endtask

    task automatic test_ovf();
        int lens [3] = '{1000, 750, 700};
        int wexp [3] = '{15, 15, 14};
        bit oexp [3] = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            sig4 = 1'b1;
            cyc(lens[i]);
            sig4 = 1'b0;
            lat = 0;
            while (mi4.meas_valid !== 1'b1 && lat < 20) begin
                cyc(1);
                lat++;
            end
            n_total++; if (mi4.meas_valid !== 1'b1) $display("FAIL ovf_timeout_%0d: got %b expected 1", lens[i], mi4.meas_valid); else n_pass++;
            n_total++; if (mi4.meas_width !== 4'(wexp[i]) || mi4.meas_ovf !== oexp[i]) $display("FAIL ovf_result_%0d: got width=%0d ovf=%b expected width=%0d ovf=%b", lens[i], mi4.meas_width, mi4.meas_ovf, wexp[i], oexp[i]); else n_pass++;
            mi4.meas_ready = 1'b1;
            cyc(1);
            mi4.meas_ready = 1'b0;
            cyc(3);
        end
    endtask

    task automatic test_lost();
        int lat;
        bit ok;
        pulse(100);
        wait_valid(20, lat, ok);
        n_total++; if (ok !== 1'b1 || mi.meas_width !== 16'd2) $display("FAIL lost_first: got ok=%b width=%0d expected ok=1 width=2", ok, mi.meas_width); else n_pass++;
        n_total++; if (mi.meas_lost !== 1'b0) $display("FAIL lost_initial: got %b expected 0", mi.meas_lost); else n_pass++;
        cyc(5);
        pulse(60);
        cyc(20);
        pulse(60);
        cyc(20);
        n_total++; if (mi.meas_valid !== 1'b1 || mi.meas_width !== 16'd2) $display("FAIL lost_hold: got valid=%b width=%0d expected valid=1 width=2", mi.meas_valid, mi.meas_width); else n_pass++;
        n_total++; if (mi.meas_lost !== 1'b1) $display("FAIL lost_set: got %b expected 1", mi.meas_lost); else n_pass++;
        accept();
        n_total++; if (mi.meas_valid !== 1'b0 || mi.meas_lost !== 1'b0) $display("FAIL lost_clear: got valid=%b lost=%b expected valid=0 lost=0", mi.meas_valid, mi.meas_lost); else n_pass++;
        cyc(3);
        pulse(200);
        wait_valid(20, lat, ok);
        n_total++; if (ok !== 1'b1 || mi.meas_width !== 16'd4 || mi.meas_lost !== 1'b0) $display("FAIL lost_next: got ok=%b width=%0d lost=%b expected ok=1 width=4 lost=0", ok, mi.meas_width, mi.meas_lost); else n_pass++;
        accept();
        cyc(3);
    endtask

    task automatic test_high_at_reset();
        int lat;
        bit ok;
        sig = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        n_total++; if (busy !== 1'b0) $display("FAIL har_busy: got %b expected 0", busy); else n_pass++;
        sig = 1'b0;
        cyc(10);
        n_total++; if (mi.meas_valid !== 1'b0) $display("FAIL har_no_result: got %b expected 0", mi.meas_valid); else n_pass++;
        pulse(400);
        wait_valid(20, lat, ok);
        n_total++; if (ok !== 1'b1 || mi.meas_width !== 16'd8) $display("FAIL har_width: got ok=%b width=%0d expected ok=1 width=8", ok, mi.meas_width); else n_pass++;
        accept();
        cyc(3);
    endtask

    task automatic test_abort();
        int lat;
        bit ok;
        sig = 1'b1;
        cyc(100);
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", busy); else n_pass++;
        rst = 1'b1;
        cyc(1);
        n_total++; if (busy !== 1'b0 || mi.meas_valid !== 1'b0) $display("FAIL abort_mid: got busy=%b valid=%b expected busy=0 valid=0", busy, mi.meas_valid); else n_pass++;
        sig = 1'b0;
        rst = 1'b0;
        cyc(5);
        pulse(100);
        wait_valid(20, lat, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL abort_pending_setup: got %b expected 1", ok); else n_pass++;
        rst = 1'b1;
        cyc(1);
        n_total++; if (mi.meas_valid !== 1'b0 || mi.meas_width !== 16'd0) $display("FAIL abort_pending: got valid=%b width=%0d expected valid=0 width=0", mi.meas_valid, mi.meas_width); else n_pass++;
        rst = 1'b0;
        cyc(5);
    endtask

    task automatic test_period();
        int lat;
        bit ok;
        sig = 1'b1;
        cyc(250);
        sig = 1'b0;
        cyc(250);
        sig = 1'b1;
        wait_valid(20, lat, ok);
        n_total++; if (ok !== 1'b1 || mi.meas_width !== 16'd10) $display("FAIL period_width: got ok=%b width=%0d expected ok=1 width=10", ok, mi.meas_width); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL period_busy: got %b expected 0", busy); else n_pass++;
        sig = 1'b0;
        accept();
        n_total++; if (mi.meas_valid !== 1'b0) $display("FAIL period_accept: got %b expected 0", mi.meas_valid); else n_pass++;
        cyc(3);
    endtask

    initial begin
        mi.meas_ready  = 1'b0;
        mi4.meas_ready = 1'b0;
        test_reset();
`ifdef PULSE_PERIOD_EN
        test_period();
`else
        test_basic();
        test_boundary();
        test_ovf();
        test_lost();
        test_high_at_reset();
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
